// File: rtl/fp_wb_queue_if.sv
// Signal bundle between the W stage / long-latency FP unit and fp_wb_queue.
// slave is the queue's view; master is the view of the logic driving it.
interface fp_wb_queue_if;
  logic        i_pipe_wb_en_f;
  logic [4:0]  i_pipe_frd_index;
  logic [31:0] i_pipe_wb_data;
  logic        i_lu_valid;
  logic        o_lu_ready;
  logic [4:0]  i_lu_frd_index;
  logic [31:0] i_lu_data;
  logic        i_issue_en;
  logic [4:0]  i_issue_frd_index;
  logic        o_W_wb_en_f;
  logic [4:0]  o_W_frd_index;
  logic [31:0] o_W_wb_data;
  logic [31:0] o_pending;
  logic        o_full;
  logic        o_empty;

  modport slave (
    input  i_pipe_wb_en_f, i_pipe_frd_index, i_pipe_wb_data,
    input  i_lu_valid, i_lu_frd_index, i_lu_data,
    input  i_issue_en, i_issue_frd_index,
    output o_lu_ready, o_W_wb_en_f, o_W_frd_index, o_W_wb_data,
    output o_pending, o_full, o_empty
  );

  modport master (
    output i_pipe_wb_en_f, i_pipe_frd_index, i_pipe_wb_data,
    output i_lu_valid, i_lu_frd_index, i_lu_data,
    output i_issue_en, i_issue_frd_index,
    input  o_lu_ready, o_W_wb_en_f, o_W_frd_index, o_W_wb_data,
    input  o_pending, o_full, o_empty
  );
endinterface

// File: rtl/fp_wb_queue.sv
// FP register-file write-port merger: pipe writeback has priority, long-latency results drain from a FIFO.
// Optional same-cycle bypass of an idle queue: define FP_WBQ_BYPASS_EN.
module fp_wb_queue #(
  parameter int unsigned DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  fp_wb_queue_if.slave wb
);
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREG   = 32;

  typedef struct packed {
    logic [IDX_W-1:0]  frd;
    logic [DATA_W-1:0] data;
  } wbq_entry_t;

  wbq_entry_t        mem_q [DEPTH];
  wbq_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [NREG-1:0]   pending_q, pending_d;

  logic              full_c;
  logic              empty_c;
  logic              push_c;
  logic              pop_c;
  logic              bypass_c;
  logic              wb_en_c;
  logic [IDX_W-1:0]  wb_idx_c;
  logic [DATA_W-1:0] wb_data_c;
  wbq_entry_t        head_c;

  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign empty_c = (count_q == '0);
  assign head_c  = mem_q[rd_ptr_q];

  // Write-port mux: pipe first, then queue head, then (optionally) the unit directly.
  always_comb begin
    wb_en_c   = 1'b0;
    wb_idx_c  = '0;
    wb_data_c = '0;
    pop_c     = 1'b0;
    bypass_c  = 1'b0;
    if (wb.i_pipe_wb_en_f) begin
      wb_en_c   = 1'b1;
      wb_idx_c  = wb.i_pipe_frd_index;
      wb_data_c = wb.i_pipe_wb_data;
    end else if (!empty_c) begin
      wb_en_c   = 1'b1;
      wb_idx_c  = head_c.frd;
      wb_data_c = head_c.data;
      pop_c     = 1'b1;
    end
`ifdef FP_WBQ_BYPASS_EN
    else if (wb.i_lu_valid) begin
      wb_en_c   = 1'b1;
      wb_idx_c  = wb.i_lu_frd_index;
      wb_data_c = wb.i_lu_data;
      bypass_c  = 1'b1;
    end
`endif
  end

  // Ready depends only on registered occupancy, so a full queue refuses even when popping.
  assign push_c = wb.i_lu_valid && !full_c && !bypass_c;

  // FIFO next state.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) begin
      mem_d[wr_ptr_q] = '{frd: wb.i_lu_frd_index, data: wb.i_lu_data};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Scoreboard: retire on queue/bypass writes, then a same-index issue re-arms the bit.
  always_comb begin
    pending_d = pending_q;
    if (pop_c) begin
      pending_d[head_c.frd] = 1'b0;
    end
    if (bypass_c) begin
      pending_d[wb.i_lu_frd_index] = 1'b0;
    end
    if (wb.i_issue_en) begin
      pending_d[wb.i_issue_frd_index] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  assign wb.o_W_wb_en_f   = wb_en_c;
  assign wb.o_W_frd_index = wb_idx_c;
  assign wb.o_W_wb_data   = wb_data_c;
  assign wb.o_pending     = pending_q;
  assign wb.o_full        = full_c;
  assign wb.o_empty       = empty_c;
  assign wb.o_lu_ready    = !full_c;
endmodule

// File: tb/tb_fp_wb_queue.sv
// Self-checking bench for fp_wb_queue: queue/scoreboard reference model plus directed literal checks.
module tb_fp_wb_queue;
  localparam int unsigned DEPTH = 4;
`ifdef FP_WBQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  fp_wb_queue_if bus();
  fp_wb_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .wb(bus));

  always #5 clk = ~clk;

  // Reference model: queue of {frd,data} and a pending bit per register.
  logic [36:0] mq[$];
  logic [31:0] mpend = '0;
  logic [36:0] mhead;
  bit          m_full, m_pop, m_byp;
  logic        exp_en;
  logic [4:0]  exp_idx;
  logic [31:0] exp_dat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mpend = '0;
    end else begin
      m_full = (mq.size() == DEPTH);
      m_pop  = !bus.i_pipe_wb_en_f && (mq.size() > 0);
      m_byp  = BYP && !bus.i_pipe_wb_en_f && (mq.size() == 0) && bus.i_lu_valid;
      if (m_pop) begin
        mhead = mq.pop_front();
        mpend[mhead[36:32]] = 1'b0;
      end
      if (m_byp) mpend[bus.i_lu_frd_index] = 1'b0;
      if (bus.i_lu_valid && !m_full && !m_byp) mq.push_back({bus.i_lu_frd_index, bus.i_lu_data});
      if (bus.i_issue_en) mpend[bus.i_issue_frd_index] = 1'b1;
    end
  end

  // Compare process: every cycle, mid low phase.
  always @(negedge clk) begin
    #1;
    exp_en = 1'b0; exp_idx = '0; exp_dat = '0;
    if (bus.i_pipe_wb_en_f) begin
      exp_en = 1'b1; exp_idx = bus.i_pipe_frd_index; exp_dat = bus.i_pipe_wb_data;
    end else if (mq.size() > 0) begin
      mhead = mq[0];
      exp_en = 1'b1; exp_idx = mhead[36:32]; exp_dat = mhead[31:0];
    end else if (BYP && bus.i_lu_valid) begin
      exp_en = 1'b1; exp_idx = bus.i_lu_frd_index; exp_dat = bus.i_lu_data;
    end
    check("m_wb_en",   32'(bus.o_W_wb_en_f),   32'(exp_en));
    check("m_wb_idx",  32'(bus.o_W_frd_index), 32'(exp_idx));
    check("m_wb_data", bus.o_W_wb_data,        exp_dat);
    check("m_pending", bus.o_pending,          mpend);
    check("m_full",    32'(bus.o_full),        32'(mq.size() == DEPTH));
    check("m_empty",   32'(bus.o_empty),       32'(mq.size() == 0));
    check("m_ready",   32'(bus.o_lu_ready),    32'(mq.size() != DEPTH));
  end

  task automatic next();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive(input bit pe, input logic [4:0] pi, input logic [31:0] pd,
                       input bit lv, input logic [4:0] li, input logic [31:0] ld,
                       input bit ie, input logic [4:0] ii);
    bus.i_pipe_wb_en_f    = pe;
    bus.i_pipe_frd_index  = pi;
    bus.i_pipe_wb_data    = pd;
    bus.i_lu_valid        = lv;
    bus.i_lu_frd_index    = li;
    bus.i_lu_data         = ld;
    bus.i_issue_en        = ie;
    bus.i_issue_frd_index = ii;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    idle();
    next();
    settle();
    check("rst_wb_en", 32'(bus.o_W_wb_en_f), 32'(0));
    check("rst_idx", 32'(bus.o_W_frd_index), 32'(0));
    check("rst_data", bus.o_W_wb_data, 32'h0);
    check("rst_pending", bus.o_pending, 32'h0);
    check("rst_full", 32'(bus.o_full), 32'(0));
    check("rst_empty", 32'(bus.o_empty), 32'(1));
    check("rst_ready", 32'(bus.o_lu_ready), 32'(1));
    next();
    rst = 1'b0;

    // Reset mid-burst with three queued results and pending = f1,f2,f8.
    next(); drive(1, 9, 32'h1234_5678, 0, 0, 0, 1, 1);
    next(); drive(1, 9, 32'h1234_5678, 1, 1, 32'h1111_1111, 1, 2);
    next(); drive(1, 9, 32'h1234_5678, 1, 2, 32'h2222_2222, 1, 8);
    next(); drive(1, 9, 32'h1234_5678, 1, 8, 32'h3333_3333, 0, 0);
    next(); drive(1, 9, 32'h1234_5678, 0, 0, 0, 0, 0);
    settle();
    check("burst_pending", bus.o_pending, 32'h0000_0106);
    check("burst_empty", 32'(bus.o_empty), 32'(0));
    idle();
    rst = 1'b1;
    #1;
    check("midrst_empty", 32'(bus.o_empty), 32'(1));
    check("midrst_pending", bus.o_pending, 32'h0);
    check("midrst_wb_en", 32'(bus.o_W_wb_en_f), 32'(0));
    next(); rst = 1'b0;
    next(); settle();
    check("postrst_empty", 32'(bus.o_empty), 32'(1));

    // Drain of a single result with the pipe idle.
    next(); drive(0, 0, 0, 0, 0, 0, 1, 5);
    next(); drive(0, 0, 0, 1, 5, 32'h3F80_0000, 0, 0);
    settle();
`ifdef FP_WBQ_BYPASS_EN
    check("byp_wb_en", 32'(bus.o_W_wb_en_f), 32'(1));
    check("byp_idx", 32'(bus.o_W_frd_index), 32'(5));
    check("byp_data", bus.o_W_wb_data, 32'h3F80_0000);
    next(); idle(); settle();
    check("byp_pend5", 32'(bus.o_pending[5]), 32'(0));
`else
    check("drain_push_wb_en", 32'(bus.o_W_wb_en_f), 32'(0));
    next(); idle(); settle();
    check("drain_wb_en", 32'(bus.o_W_wb_en_f), 32'(1));
    check("drain_idx", 32'(bus.o_W_frd_index), 32'(5));
    check("drain_data", bus.o_W_wb_data, 32'h3F80_0000);
    check("drain_pend5_before", 32'(bus.o_pending[5]), 32'(1));
`endif
    next(); settle();
    check("drain_pend5_after", 32'(bus.o_pending[5]), 32'(0));
    check("drain_empty", 32'(bus.o_empty), 32'(1));

    // Pipe priority starves the queued f2 for three cycles.
    next(); drive(0, 0, 0, 0, 0, 0, 1, 2);
    next(); drive(1, 9, 32'h1234_5678, 1, 2, 32'hAAAA_AAAA, 0, 0);
    settle(); check("prio_idx_c1", 32'(bus.o_W_frd_index), 32'(9));
    next(); drive(1, 9, 32'h1234_5678, 0, 0, 0, 0, 0);
    settle(); check("prio_idx_c2", 32'(bus.o_W_frd_index), 32'(9));
    check("prio_pend2_c2", 32'(bus.o_pending[2]), 32'(1));
    next(); settle();
    check("prio_data_c3", bus.o_W_wb_data, 32'h1234_5678);
    next(); idle(); settle();
    check("prio_idx_c4", 32'(bus.o_W_frd_index), 32'(2));
    check("prio_data_c4", bus.o_W_wb_data, 32'hAAAA_AAAA);
    check("prio_pend2_c4", 32'(bus.o_pending[2]), 32'(1));
    next(); settle();
    check("prio_pend2_after", 32'(bus.o_pending[2]), 32'(0));

    // Fill to full behind a busy pipe, hold off a fifth, drain in order; repeat for wrap.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) begin
        next(); drive(1, 9, 32'h1234_5678, 1, 5'(10 + k), 32'h1000_0000 + 32'(r * 256 + k), 0, 0);
      end
      next(); drive(1, 9, 32'h1234_5678, 1, 20, 32'hDEAD_BEEF, 0, 0);
      settle();
      check("wrap_full", 32'(bus.o_full), 32'(1));
      check("wrap_ready", 32'(bus.o_lu_ready), 32'(0));
      for (int k = 0; k < 4; k++) begin
        next(); idle(); settle();
        check("wrap_idx", 32'(bus.o_W_frd_index), 32'(10 + k));
        check("wrap_data", bus.o_W_wb_data, 32'h1000_0000 + 32'(r * 256 + k));
      end
      next(); settle();
      check("wrap_empty", 32'(bus.o_empty), 32'(1));
    end

    // Queue retires f7 in the same cycle a new op to f7 issues.
    next(); drive(0, 0, 0, 0, 0, 0, 1, 7);
    next(); drive(1, 9, 32'h1234_5678, 1, 7, 32'h7777_7777, 0, 0);
    next(); drive(0, 0, 0, 0, 0, 0, 1, 7);
    settle(); check("coll_idx", 32'(bus.o_W_frd_index), 32'(7));
    next(); idle(); settle();
    check("coll_pend7", 32'(bus.o_pending[7]), 32'(1));

    // Simultaneous push and pop with two entries queued.
    next(); drive(1, 9, 32'h1234_5678, 1, 3, 32'hA0A0_A0A0, 0, 0);
    next(); drive(1, 9, 32'h1234_5678, 1, 4, 32'hB0B0_B0B0, 0, 0);
    next(); drive(0, 0, 0, 1, 6, 32'hC0C0_C0C0, 0, 0);
    settle(); check("pp_data0", bus.o_W_wb_data, 32'hA0A0_A0A0);
    next(); idle(); settle();
    check("pp_data1", bus.o_W_wb_data, 32'hB0B0_B0B0);
    check("pp_empty1", 32'(bus.o_empty), 32'(0));
    next(); settle();
    check("pp_data2", bus.o_W_wb_data, 32'hC0C0_C0C0);
    next(); settle();
    check("pp_empty", 32'(bus.o_empty), 32'(1));

    // Randomized traffic against the model, with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      next();
      drive($urandom_range(0, 9) < 4, 5'($urandom), $urandom,
            $urandom_range(0, 1) == 1, 5'($urandom), $urandom,
            $urandom_range(0, 9) < 3, 5'($urandom));
      rst = ($urandom_range(0, 199) == 0);
    end
    next(); idle(); rst = 1'b0;
    repeat (4) next();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
